md_ctrl: RTL

//  EX-stage multiply/divide sequencer and HI/LO register owner. Runs a 32-iteration

---
 rtl/md_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: EX-stage multiply/divide sequencer and HI/LO register owner.
// Runs a WIDTH-iteration shift-add multiply or restoring divide on latched
// operand magnitudes, holds the pipeline via stallreq until the result is
// ready, then commits HI/LO when EX is allowed to advance. Also executes
// MTHI/MTLO and exposes hi/lo for MFHI/MFLO.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall[STALL_W-1:0] pipeline stall bus, bit 3 = EX held
//   cancel             EX flushed, abort any in-flight operation
//   op_div/op_divu/op_mult/op_multu  operation requests (held while stalled)
//   op_mthi/op_mtlo    write src1 into HI/LO
//   src1, src2         rs / rt operands
//   stallreq           combinational stall request into the stall controller
//   busy               sequencer not idle (registered)
//   hi, lo             HI/LO architectural registers
module md_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               cancel,
  input  logic               op_div,
  input  logic               op_divu,
  input  logic               op_mult,
  input  logic               op_multu,
  input  logic               op_mthi,
  input  logic               op_mtlo,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  output logic               stallreq,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DIV_ZERO = 3'd1;
  localparam logic [2:0] DIV_ON   = 3'd2;
  localparam logic [2:0] MUL_ON   = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;

  // acc_hi/acc_lo: remainder/quotient while dividing, running product while multiplying
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] b_reg;
  logic             s1_neg;
  logic             s2_neg;

  logic             start;
  logic             is_div;
  logic             is_signed;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic             commit;
  logic             mt_ok;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             mul_mode;

  // Request decode; with one-hot ops the priority only selects signedness
  assign start     = (op_div | op_divu | op_mult | op_multu) & ~cancel;
  assign is_div    = op_div | op_divu;
  assign is_signed = op_div | (~op_divu & op_mult);
  assign src1_neg  = is_signed & src1[WIDTH-1];
  assign src2_neg  = is_signed & src2[WIDTH-1];
  assign abs1      = src1_neg ? WIDTH'(-src1) : src1;
  assign abs2      = src2_neg ? WIDTH'(-src2) : src2;

  // One restoring-divide step and one shift-add multiply step
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : (WIDTH+1)'(0));

  // Sign fix-up of the finished magnitude result
  assign prod_fix = s1_neg ^ s2_neg ? (2*WIDTH)'(-{acc_hi, acc_lo}) : {acc_hi, acc_lo};
  assign quo_fix  = s1_neg ^ s2_neg ? WIDTH'(-acc_lo) : acc_lo;
  assign rem_fix  = s1_neg ? WIDTH'(-acc_hi) : acc_hi;
  assign res_hi   = mul_mode ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
  assign res_lo   = mul_mode ? prod_fix[WIDTH-1:0]       : quo_fix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and combinational controls
  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    commit    = 1'b0;
    mt_ok     = 1'b0;
    case (state)
      IDLE: begin
        stallreq = start;
        mt_ok    = ~stall[3] & ~cancel;
        if (start) begin
          if (is_div) state_nxt = (src2 == '0) ? DIV_ZERO : DIV_ON;
          else        state_nxt = MUL_ON;
        end
      end
      DIV_ZERO: begin
        stallreq  = 1'b1;
        state_nxt = DONE;
      end
      DIV_ON, MUL_ON: begin
        stallreq = 1'b1;
        if (cnt == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        if (!stall[3]) begin
          commit    = ~cancel;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (cancel) state_nxt = IDLE;
    if (cancel || rst) stallreq = 1'b0;
  end

  // Datapath, iteration counter, HI/LO and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_reg    <= '0;
      s1_neg   <= 1'b0;
      s2_neg   <= 1'b0;
      mul_mode <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            mul_mode <= ~is_div;
            if (is_div && src2 == '0) begin
              // divide by zero: raw dividend to HI, all-ones to LO, no fix-up
              acc_hi <= src1;
              acc_lo <= '1;
              b_reg  <= '0;
              s1_neg <= 1'b0;
              s2_neg <= 1'b0;
            end else if (is_div) begin
              acc_hi <= '0;
              acc_lo <= abs1;
              b_reg  <= abs2;
              s1_neg <= src1_neg;
              s2_neg <= src2_neg;
            end else begin
              acc_hi <= '0;
              acc_lo <= abs2;
              b_reg  <= abs1;
              s1_neg <= src1_neg;
              s2_neg <= src2_neg;
            end
          end
        end
        DIV_ON: begin
          cnt <= cnt + CNT_W'(1);
          if (!div_diff[WIDTH]) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
        end
        MUL_ON: begin
          cnt <= cnt + CNT_W'(1);
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
        end
        default: ;
      endcase
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (mt_ok) begin
        if (op_mthi) hi <= src1;
        if (op_mtlo) lo <= src1;
      end
    end
  end

endmodule
